jtgng_objdma: RTL and testbench
===============================

Name: jtgng_objdma

Overview:
- Bus-master side of the main CPU's bus-sharing interface. Copies the 512-byte object table from the top of main CPU RAM into the object line-buffer RAM.
- A CPU write strobe (OKOUT) arms a transfer. The transfer starts at the next vertical-blank start.
- Sequence: request the bus (bus_req), wait for grant (bus_ack), drive blcnten/obj_AB to read CPU RAM, write each byte to the object buffer, release the bus.

Parameters:
- AW, 9, object table address width; table size = 2**AW bytes.
- TOUT, 255, bus_ack timeout in cen6 ticks (used only with JTGNG_OBJDMA_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- cen6  in  1  6MHz clock enable; all state advances only when cen6=1
- LVBL  in  1  vertical blanking when 0
- OKOUT  in  1  CPU chip-select for DMA trigger register (level, may last several cen6)
- bus_ack  in  1  bus granted by CPU (BA&BS)
- bus_req  out  1  bus request to CPU (drives CPU halt)
- blcnten  out  1  RAM address mux select: obj_AB owns CPU RAM
- obj_AB  out  AW  CPU RAM read address (RAM maps it to {4'hf,obj_AB})
- ram_dout  in  8  CPU RAM read data, one cen6 tick after address
- buf_addr  out  AW  object buffer write address
- buf_data  out  8  object buffer write data
- buf_we  out  1  object buffer write enable, 1 clk wide, coincident with cen6
- busy  out  1  high from arm until bus released
- dma_done  out  1  one-cen6-tick pulse after the last byte is written
- dma_err  out  1  one-cen6-tick pulse on timeout abort (0 without macro)

Behaviour:
- Reset (rst_n=0 on posedge clk):
  - Outputs reset to 0: bus_req, blcnten, obj_AB, buf_addr, buf_data, buf_we, busy, dma_done, dma_err.
  - Internal state: state=IDLE, pending=0.
- Edge detection, evaluated on cen6 ticks:
  - okout_rise = OKOUT & ~OKOUT_last.
  - vb_start = LVBL_last & ~LVBL.
- States:
  - IDLE: on okout_rise -> ARMED, busy=1.
  - ARMED: on vb_start -> REQ, bus_req=1. LVBL already low when armed does not start a transfer; ARMED waits for the next falling edge.
  - REQ: bus_req=1. On bus_ack=1 -> COPY, blcnten=1, obj_AB=0.
  - COPY:
    - Each cen6 tick with bus_ack=1: obj_AB increments.
    - rd_valid (registered) records that the previous tick presented a valid address.
    - When rd_valid=1: buf_we=1, buf_addr=previous obj_AB, buf_data=ram_dout.
    - On the tick obj_AB=2**AW-1 is presented -> DRAIN.
  - DRAIN: one tick to write the final byte (buf_addr=2**AW-1) -> IDLE. On that transition: bus_req=0, blcnten=0, dma_done pulses, busy=0.
    - If pending=1: go to ARMED instead, pending cleared, busy stays 1.
- Latency and throughput:
  - 2**AW reads + 1 drain tick: 513 cen6 ticks from grant to bus release at AW=9.
  - Byte n written exactly one cen6 tick after obj_AB=n.
- bus_ack drops during COPY:
  - blcnten=0 and obj_AB is held.
  - No buf_we on ticks whose previous tick had no valid read.
  - Resume re-presents the held address. No byte is skipped or duplicated.
- okout_rise while busy (ARMED/REQ/COPY/DRAIN) sets pending. Multiple rises collapse to one pending transfer.
- vb_start in IDLE/REQ/COPY/DRAIN: ignored.
- rst_n low mid-COPY: bus released on the same clock edge; no further buf_we.
- buf_we never asserts when cen6=0.

Optional Feature:
- Macro: JTGNG_OBJDMA_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in REQ, counting cen6 ticks with bus_ack=0.
  - On reaching TOUT: bus_req drops, dma_err pulses, state -> IDLE, busy=0, pending cleared.
  - The counter clears on entering REQ.
- Undefined: REQ waits indefinitely; dma_err tied 0.

Test Plan:
- Fill RAM 0x1E00-0x1FFF with byte=addr[7:0]^0x5A. OKOUT pulse, then LVBL fall, bus_ack 4 ticks after bus_req. Required: 512 buf_we, buf_data[n]=n[7:0]^0x5A, bus_req released 513 cen6 after grant, single dma_done.
- OKOUT pulse while LVBL already 0 -> no bus_req until LVBL rises then falls again.
- bus_ack low for 10 ticks at obj_AB=0x100 -> obj_AB holds 0x100, buf_we gap, all 512 bytes still written once, in order.
- Two OKOUT pulses during COPY -> exactly one extra transfer at the next vb_start; total dma_done count=2.
- rst_n=0 at obj_AB=0x080 -> next clk: bus_req=0, blcnten=0, buf_we=0, busy=0; no further writes.
- With JTGNG_OBJDMA_TIMEOUT_EN, bus_ack held 0 -> bus_req drops and dma_err pulses 255 cen6 ticks after entering REQ; without macro bus_req stays 1.

Source files
------------

// File: rtl/jtgng_objdma.sv
// rtl/jtgng_objdma.sv - copies the object table from main CPU RAM into the object line buffer
// Optional bus-grant timeout abort is enabled by defining JTGNG_OBJDMA_TIMEOUT_EN.
module jtgng_objdma #(
  parameter int AW   = 9,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen6,
  input  logic          LVBL,
  input  logic          OKOUT,
  input  logic          bus_ack,
  output logic          bus_req,
  output logic          blcnten,
  output logic [AW-1:0] obj_AB,
  input  logic [7:0]    ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_data,
  output logic          buf_we,
  output logic          busy,
  output logic          dma_done,
  output logic          dma_err
);

  typedef enum logic [2:0] {IDLE, ARMED, REQ, COPY, DRAIN} state_t;
  localparam logic [AW-1:0] LAST = '1;

  if (TOUT < 1 || TOUT > 255) begin : g_tout_check
    $error("TOUT must fit the 8-bit timeout counter");
  end

  state_t        state_q;
  logic          pending_q, okout_last_q, lvbl_last_q, rd_valid_q;
  logic          bus_req_q, blcnten_q, busy_q, done_q, err_q;
  logic [AW-1:0] obj_ab_q;
`ifdef JTGNG_OBJDMA_TIMEOUT_EN
  localparam logic [7:0] TOUT_M1 = 8'(TOUT - 1);
  logic [7:0] tout_cnt_q;
`endif

  logic          okout_rise, vb_start;
  logic [AW-1:0] obj_ab_inc;

  assign okout_rise = OKOUT & ~okout_last_q;
  assign vb_start   = lvbl_last_q & ~LVBL;
  assign obj_ab_inc = obj_ab_q + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      okout_last_q <= 1'b0;
      lvbl_last_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      blcnten_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      obj_ab_q     <= '0;
`ifdef JTGNG_OBJDMA_TIMEOUT_EN
      tout_cnt_q   <= 8'd0;
`endif
    end else if (cen6) begin
      okout_last_q <= OKOUT;
      lvbl_last_q  <= LVBL;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (okout_rise && state_q != IDLE) pending_q <= 1'b1;
      case (state_q)
        IDLE: if (okout_rise) begin
          state_q <= ARMED;
          busy_q  <= 1'b1;
        end
        ARMED: if (vb_start) begin
          state_q   <= REQ;
          bus_req_q <= 1'b1;
`ifdef JTGNG_OBJDMA_TIMEOUT_EN
          tout_cnt_q <= 8'd0;
`endif
        end
        REQ: begin
          if (bus_ack) begin
            state_q    <= COPY;
            blcnten_q  <= 1'b1;
            obj_ab_q   <= '0;
            rd_valid_q <= 1'b1;
          end
`ifdef JTGNG_OBJDMA_TIMEOUT_EN
          else if (tout_cnt_q == TOUT_M1) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            tout_cnt_q <= tout_cnt_q + 8'd1;
          end
`endif
        end
        COPY, DRAIN: begin
          // A read is only trusted if the bus was ours for the whole tick, so
          // losing the grant discards the pending byte and resume re-presents it.
          if (!bus_ack) begin
            blcnten_q  <= 1'b0;
            rd_valid_q <= 1'b0;
          end else if (!rd_valid_q) begin
            blcnten_q  <= 1'b1;
            rd_valid_q <= 1'b1;
          end else if (state_q == COPY) begin
            obj_ab_q <= obj_ab_inc;
            if (obj_ab_inc == LAST) state_q <= DRAIN;
          end else begin
            bus_req_q  <= 1'b0;
            blcnten_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b1;
            pending_q  <= 1'b0;
            if (pending_q || okout_rise) begin
              state_q <= ARMED;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req  = bus_req_q;
  assign blcnten  = blcnten_q;
  assign obj_AB   = obj_ab_q;
  assign buf_addr = obj_ab_q;
  assign buf_data = rd_valid_q ? ram_dout : 8'h00;
  assign buf_we   = rst_n & cen6 & rd_valid_q & bus_ack;
  assign busy     = busy_q;
  assign dma_done = done_q;
  assign dma_err  = err_q;

endmodule

// File: tb/tb_jtgng_objdma.sv
// tb/tb_jtgng_objdma.sv - randomized self-checking bench for jtgng_objdma
module tb_jtgng_objdma;

  logic       clk = 1'b0, rst_n = 1'b0, cen6 = 1'b0, LVBL = 1'b1, OKOUT = 1'b0, bus_ack = 1'b0;
  logic       bus_req, blcnten, buf_we, busy, dma_done, dma_err;
  logic [8:0] obj_AB, buf_addr;
  logic [7:0] ram_dout, buf_data;
  logic [7:0] mem [512];

  int vectors = 0, miscompares = 0;
  int tick_n = 0, grant_tick = -1, rel_tick = -1, req_tick = -1;
  int done_cnt, err_cnt, we_bad, hold_bad, req_cnt, ack_lat = 4;
  int drop_addr = -1, drop_left = 0, p1 = -1, p2 = -1;
  bit ack_enable = 1'b1, dropping = 1'b0, okout_manual = 1'b0, req_prev = 1'b0;
  int wr_addr[$], wr_data[$], wr_tick[$];

  always #5 clk = ~clk;
  assign ram_dout = mem[obj_AB];

  jtgng_objdma dut (
    .clk(clk), .rst_n(rst_n), .cen6(cen6), .LVBL(LVBL), .OKOUT(OKOUT),
    .bus_ack(bus_ack), .bus_req(bus_req), .blcnten(blcnten), .obj_AB(obj_AB),
    .ram_dout(ram_dout), .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .busy(busy), .dma_done(dma_done), .dma_err(dma_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cen6 tick: CPU grant model, stimulus, write capture and pulse counting.
  task automatic tick();
    int idle;
    idle = $urandom_range(0, 2);
    if (!bus_req) req_cnt = 0;
    else if (req_cnt < ack_lat) req_cnt++;
    if (drop_left > 0 && blcnten && obj_AB == drop_addr) dropping = 1'b1;
    bus_ack = bus_req && ack_enable && (req_cnt >= ack_lat) && !dropping;
    if (dropping) begin
      if (obj_AB != drop_addr) hold_bad++;
      drop_left--;
      if (drop_left == 0) dropping = 1'b0;
    end
    if (bus_ack && grant_tick < 0) grant_tick = tick_n + 1;
    OKOUT = okout_manual || (blcnten && (obj_AB == p1 || obj_AB == p2));
    repeat (idle) begin
      @(negedge clk); cen6 = 1'b0; #1;
      if (buf_we) we_bad++;
    end
    @(negedge clk); cen6 = 1'b1; #1;
    if (buf_we) begin
      wr_addr.push_back(buf_addr);
      wr_data.push_back(buf_data);
      wr_tick.push_back(tick_n + 1);
    end
    @(posedge clk); #1;
    cen6 = 1'b0;
    tick_n++;
    if (dma_done) done_cnt++;
    if (dma_err) err_cnt++;
    if (req_prev && !bus_req) rel_tick = tick_n;
    if (!req_prev && bus_req) req_tick = tick_n;
    req_prev = bus_req;
  endtask

  task automatic clear();
    wr_addr.delete(); wr_data.delete(); wr_tick.delete();
    done_cnt = 0; err_cnt = 0; we_bad = 0; hold_bad = 0;
    grant_tick = -1; req_tick = -1; dropping = 1'b0;
  endtask

  task automatic arm();
    okout_manual = 1'b1;
    repeat (2) tick();
    okout_manual = 1'b0;
    tick();
  endtask

  task automatic vblank();
    LVBL = 1'b1;
    repeat (3) tick();
    LVBL = 1'b0;
    tick();
  endtask

  task automatic run_until_release(input string tag);
    int r0, n;
    r0 = rel_tick;
    n = 0;
    while (rel_tick == r0 && n < 1500) begin
      tick();
      n++;
    end
    check({tag, "_released"}, int'(rel_tick != r0), 1);
  endtask

  // Expected: every transfer writes addresses 0..511 once, in order, with mem contents.
  task automatic check_writes(input string tag, input int nxfer);
    int bad;
    bad = 0;
    check({tag, "_wr_count"}, wr_addr.size(), 512 * nxfer);
    foreach (wr_addr[i])
      if (wr_addr[i] != i % 512 || wr_data[i] != int'(mem[i % 512])) bad++;
    check({tag, "_wr_data"}, bad, 0);
  endtask

  task automatic fill_random();
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0;
    foreach (mem[i]) mem[i] = 8'(i) ^ 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_ctrl", {blcnten, busy, dma_done, dma_err, buf_we}, 0);
    check("rst_obj_AB", obj_AB, 0);
    check("rst_buf", {buf_addr, buf_data}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic transfer: ack 4 ticks after request, pattern addr^0x5A.
    clear();
    arm();
    check("s1_armed_busy", busy, 1);
    check("s1_armed_no_req", bus_req, 0);
    vblank();
    run_until_release("s1");
    check_writes("s1", 1);
    check("s1_grant_to_release", rel_tick - grant_tick + 1, 513);
    check("s1_first_write_lat", wr_tick.size() > 0 ? wr_tick[0] - grant_tick : -1, 1);
    check("s1_done", done_cnt, 1);
    check("s1_busy_end", busy, 0);
    check("s1_err", err_cnt, 0);

    // Armed while LVBL is already low: must wait for a fresh falling edge.
    clear();
    fill_random();
    ack_lat = $urandom_range(1, 8);
    LVBL = 1'b0;
    repeat (3) tick();
    arm();
    repeat (20) tick();
    check("s2_no_req_lvbl_low", req_tick, -1);
    check("s2_busy_armed", busy, 1);
    vblank();
    run_until_release("s2");
    check_writes("s2", 1);
    check("s2_grant_to_release", rel_tick - grant_tick + 1, 513);
    check("s2_done", done_cnt, 1);

    // Grant withdrawn for 10 ticks at obj_AB=0x100.
    clear();
    fill_random();
    ack_lat = $urandom_range(1, 8);
    drop_addr = 'h100;
    drop_left = 10;
    arm();
    vblank();
    run_until_release("s3");
    check_writes("s3", 1);
    check("s3_drop_applied", drop_left, 0);
    check("s3_addr_held", hold_bad, 0);
    check("s3_write_gap", wr_tick.size() > 256 ? int'(wr_tick[256] - wr_tick[255] > 10) : 0, 1);
    check("s3_done", done_cnt, 1);
    drop_addr = -1;

    // Two OKOUT pulses during COPY collapse into one extra transfer.
    clear();
    fill_random();
    p1 = $urandom_range('h10, 'h7F);
    p2 = $urandom_range('h90, 'h1F0);
    arm();
    vblank();
    run_until_release("s4a");
    p1 = -1; p2 = -1;
    check("s4_busy_pending", busy, 1);
    check("s4_done_first", done_cnt, 1);
    vblank();
    run_until_release("s4b");
    check_writes("s4", 2);
    check("s4_done_total", done_cnt, 2);
    check("s4_busy_end", busy, 0);
    req_tick = -1;
    vblank();
    repeat (20) tick();
    check("s4_no_third", req_tick, -1);

    // Reset in the middle of COPY.
    clear();
    fill_random();
    arm();
    vblank();
    n = 0;
    while (!(blcnten && obj_AB == 9'h080) && n < 1000) begin
      tick();
      n++;
    end
    check("s5_reached_080", int'(blcnten && obj_AB == 9'h080), 1);
    check("s5_writes_before", wr_addr.size(), 128);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("s5_rst_bus", {bus_req, blcnten}, 0);
    check("s5_rst_we_busy", {buf_we, busy}, 0);
    @(negedge clk); rst_n = 1'b1;
    req_prev = 1'b0;
    n = wr_addr.size();
    vblank();
    repeat (10) tick();
    check("s5_no_more_writes", wr_addr.size(), n);

    // Grant never arrives.
    clear();
    ack_enable = 1'b0;
    arm();
    vblank();
    n = 0;
    while (!bus_req && n < 50) begin
      tick();
      n++;
    end
    check("s6_req_seen", bus_req, 1);
    r0 = rel_tick;
    n = 0;
    while (bus_req && n < 300) begin
      tick();
      n++;
    end
`ifdef JTGNG_OBJDMA_TIMEOUT_EN
    check("s6_timeout_ticks", rel_tick - req_tick, 255);
    check("s6_err_pulse", err_cnt, 1);
    check("s6_busy_end", busy, 0);
    ack_enable = 1'b1;
`else
    check("s6_req_held", bus_req, 1);
    check("s6_no_err", err_cnt, 0);
    check("s6_no_release", int'(rel_tick == r0), 1);
    ack_enable = 1'b1;
    run_until_release("s6");
    check("s6_done_late", done_cnt, 1);
`endif
    check("we_gated_by_cen6", we_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
